// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Control end of the IF/ID -> EX/MEM pipeline register. It drives the enable
//   of that register and the PC/fetch enables. It inserts NOP bubbles on
//   load-use hazards and taken branches, and freezes the front-end while data
//   memory is busy. Saturating debug counters and a sticky memory-timeout flag
//   are kept alongside.
//
// Ports:
//   CLK            in   clock, all state updates on posedge
//   RESET          in   synchronous active-high reset
//   id_RA/id_RB    in   source registers of the instruction in IF/ID
//   id_USE_A/B     in   instruction actually reads RA / RB
//   ex_WC          in   destination register held in EX/MEM
//   ex_W_RB        in   EX/MEM instruction writes the register bank
//   ex_S_MXRB      in   EX/MEM writeback source select
//   br_TAKEN       in   branch resolved taken in EX this cycle
//   mem_BUSY       in   data memory not ready, pipeline must hold
//   EN_PC          out  PC register enable
//   EN_IF          out  fetch/instruction register enable
//   FLUSH_IF       out  clear fetched (wrong-path) instruction
//   EN_IFID_EXMEM  out  enable of the IF/ID -> EX/MEM register
//   BUBBLE         out  force that register to load NOP fields
//   state          out  0 = RUN, 1 = FLUSH
//   stall_cnt      out  load-use stall cycles, saturating
//   flush_cnt      out  cycles with FLUSH_IF = 1, saturating
//   wait_cnt       out  freeze cycles, saturating
//   err_TIMEOUT    out  sticky: a busy period reached MEM_TIMEOUT cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter logic [1:0] LOAD_SEL     = 2'b01,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         MEM_TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  id_RA,
  input  logic [3:0]  id_RB,
  input  logic        id_USE_A,
  input  logic        id_USE_B,
  input  logic [3:0]  ex_WC,
  input  logic        ex_W_RB,
  input  logic [1:0]  ex_S_MXRB,
  input  logic        br_TAKEN,
  input  logic        mem_BUSY,
  output logic        EN_PC,
  output logic        EN_IF,
  output logic        FLUSH_IF,
  output logic        EN_IFID_EXMEM,
  output logic        BUBBLE,
  output logic        state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] wait_cnt,
  output logic        err_TIMEOUT
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Flush counter value loaded on a taken branch (the branch cycle itself is
  // the first bubble, so only the remaining ones are counted here).
  localparam logic [2:0]  FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t      r_state;
  logic [2:0]  r_fcnt;
  logic [15:0] r_busy_run;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_wait_cnt;
  logic        r_err;

  logic        w_lu;
  logic [15:0] w_busy_inc;
  logic        w_en_pc;
  logic        w_en_if;
  logic        w_flush_if;
  logic        w_en_reg;
  logic        w_bubble;
  state_t      w_state_nxt;
  logic [2:0]  w_fcnt_nxt;
  logic [15:0] w_busy_nxt;
  logic        w_err_nxt;
  logic        w_inc_stall;
  logic        w_inc_flush;
  logic        w_inc_wait;

  // Load in EX/MEM whose destination matches a source actually read in IF/ID.
  // R0 gets no special treatment.
  assign w_lu = ex_W_RB && (ex_S_MXRB == LOAD_SEL) &&
                ((id_USE_A && (id_RA == ex_WC)) || (id_USE_B && (id_RB == ex_WC)));

  assign w_busy_inc = sat_inc(r_busy_run);

  // Control outputs and next-state, priority RESET > busy > FLUSH > branch > LU.
  always_comb begin
    w_en_pc     = 1'b0;
    w_en_if     = 1'b0;
    w_flush_if  = 1'b0;
    w_en_reg    = 1'b0;
    w_bubble    = 1'b0;
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_busy_nxt  = 16'd0;
    w_err_nxt   = r_err;
    w_inc_stall = 1'b0;
    w_inc_flush = 1'b0;
    w_inc_wait  = 1'b0;

    if (RESET) begin
      // Clock a NOP into the pipeline register while in reset.
      w_en_reg = 1'b1;
      w_bubble = 1'b1;
    end else if (mem_BUSY) begin
      // Freeze: everything holds, only the busy bookkeeping moves.
      w_inc_wait = 1'b1;
      w_busy_nxt = w_busy_inc;
      if (w_busy_inc == TIMEOUT_VAL) begin
        w_err_nxt = 1'b1;
      end else begin
        w_err_nxt = r_err;
      end
    end else if (r_state == ST_FLUSH) begin
      w_en_pc     = 1'b1;
      w_en_if     = 1'b1;
      w_flush_if  = 1'b1;
      w_en_reg    = 1'b1;
      w_bubble    = 1'b1;
      w_inc_flush = 1'b1;
      // A zero count is not reachable, but exit FLUSH rather than wrap.
      if (r_fcnt <= 3'd1) begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = 3'd0;
      end else begin
        w_fcnt_nxt  = r_fcnt - 3'd1;
      end
    end else if (br_TAKEN) begin
      w_en_pc     = 1'b1;
      w_en_if     = 1'b1;
      w_flush_if  = 1'b1;
      w_en_reg    = 1'b1;
      w_bubble    = 1'b1;
      w_inc_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = ST_FLUSH;
        w_fcnt_nxt  = FLUSH_INIT;
      end else begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = 3'd0;
      end
    end else if (w_lu) begin
      // Hold PC/fetch, push one bubble; next cycle EX/MEM holds the NOP.
      w_en_reg    = 1'b1;
      w_bubble    = 1'b1;
      w_inc_stall = 1'b1;
    end else begin
      w_en_pc  = 1'b1;
      w_en_if  = 1'b1;
      w_en_reg = 1'b1;
    end
  end

  // State, flush counter, busy run, debug counters and sticky error.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_RUN;
      r_fcnt      <= 3'd0;
      r_busy_run  <= 16'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
      r_wait_cnt  <= 16'd0;
      r_err       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_busy_run <= w_busy_nxt;
      r_err      <= w_err_nxt;
      if (w_inc_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_inc_flush) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
      if (w_inc_wait) begin
        r_wait_cnt <= sat_inc(r_wait_cnt);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  assign EN_PC         = w_en_pc;
  assign EN_IF         = w_en_if;
  assign FLUSH_IF      = w_flush_if;
  assign EN_IFID_EXMEM = w_en_reg;
  assign BUBBLE        = w_bubble;
  assign state         = r_state;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign wait_cnt      = r_wait_cnt;
  assign err_TIMEOUT   = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic        CLK;
  logic        RESET;
  logic [3:0]  id_RA;
  logic [3:0]  id_RB;
  logic        id_USE_A;
  logic        id_USE_B;
  logic [3:0]  ex_WC;
  logic        ex_W_RB;
  logic [1:0]  ex_S_MXRB;
  logic        br_TAKEN;
  logic        mem_BUSY;
  logic        EN_PC;
  logic        EN_IF;
  logic        FLUSH_IF;
  logic        EN_IFID_EXMEM;
  logic        BUBBLE;
  logic        state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] wait_cnt;
  logic        err_TIMEOUT;

  int n_cmp;
  int n_err;

  pipe_hazard_ctrl #(
    .LOAD_SEL(2'b01),
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT(16)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .id_RA(id_RA),
    .id_RB(id_RB),
    .id_USE_A(id_USE_A),
    .id_USE_B(id_USE_B),
    .ex_WC(ex_WC),
    .ex_W_RB(ex_W_RB),
    .ex_S_MXRB(ex_S_MXRB),
    .br_TAKEN(br_TAKEN),
    .mem_BUSY(mem_BUSY),
    .EN_PC(EN_PC),
    .EN_IF(EN_IF),
    .FLUSH_IF(FLUSH_IF),
    .EN_IFID_EXMEM(EN_IFID_EXMEM),
    .BUBBLE(BUBBLE),
    .state(state),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .wait_cnt(wait_cnt),
    .err_TIMEOUT(err_TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp = n_cmp + 1;
    if (obs !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_RA     = 4'd0;
    id_RB     = 4'd0;
    id_USE_A  = 1'b0;
    id_USE_B  = 1'b0;
    ex_WC     = 4'd0;
    ex_W_RB   = 1'b0;
    ex_S_MXRB = 2'b00;
    br_TAKEN  = 1'b0;
    mem_BUSY  = 1'b0;
  endtask

  // Load into r5 in EX/MEM, consumer reads r5 through port B.
  task automatic set_lu_b();
    ex_W_RB   = 1'b1;
    ex_S_MXRB = 2'b01;
    ex_WC     = 4'd5;
    id_RB     = 4'd5;
    id_USE_B  = 1'b1;
  endtask

  // Enables packed as {EN_PC, EN_IF, FLUSH_IF, EN_IFID_EXMEM, BUBBLE}.
  function automatic logic [4:0] ctl();
    return {EN_PC, EN_IF, FLUSH_IF, EN_IFID_EXMEM, BUBBLE};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    RESET    = 1'b1;
    mem_BUSY = 1'b1;
    br_TAKEN = 1'b1;
    #1;
    chk("reset_ctl", 32'(ctl()), 32'h03);
    tick();
    tick();
    chk("reset_ctl_held", 32'(ctl()), 32'h03);

    RESET = 1'b0;
    idle();
    #1;
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(err_TIMEOUT), 32'd0);
    chk("normal_ctl", 32'(ctl()), 32'h1A);

    // Load-use on RB.
    set_lu_b();
    #1;
    chk("lu_ctl", 32'(ctl()), 32'h03);
    tick();
    idle();
    #1;
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_after_ctl", 32'(ctl()), 32'h1A);

    // Not a load: no stall.
    set_lu_b();
    ex_S_MXRB = 2'b00;
    #1;
    chk("nolu_sel_ctl", 32'(ctl()), 32'h1A);
    tick();
    // RB not used: no stall.
    set_lu_b();
    id_USE_B = 1'b0;
    #1;
    chk("nolu_use_ctl", 32'(ctl()), 32'h1A);
    tick();
    chk("nolu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load-use through RA, on R0.
    idle();
    ex_W_RB   = 1'b1;
    ex_S_MXRB = 2'b01;
    ex_WC     = 4'd0;
    id_RA     = 4'd0;
    id_USE_A  = 1'b1;
    #1;
    chk("lu_ra_r0_ctl", 32'(ctl()), 32'h03);
    tick();
    idle();
    #1;
    chk("lu_ra_stall_cnt", 32'(stall_cnt), 32'd2);

    // Taken branch, re-asserted during FLUSH with a load-use present.
    br_TAKEN = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl()), 32'h1F);
    chk("br_state0", 32'(state), 32'd0);
    tick();
    set_lu_b();
    #1;
    chk("br_flush_state", 32'(state), 32'd1);
    chk("br_flush_ctl", 32'(ctl()), 32'h1F);
    tick();
    idle();
    #1;
    chk("br_back_run", 32'(state), 32'd0);
    chk("br_back_ctl", 32'(ctl()), 32'h1A);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("br_stall_unch", 32'(stall_cnt), 32'd2);

    // Branch and load-use in the same cycle: branch wins.
    set_lu_b();
    br_TAKEN = 1'b1;
    #1;
    chk("brlu_ctl", 32'(ctl()), 32'h1F);
    tick();
    idle();
    #1;
    chk("brlu_state", 32'(state), 32'd1);
    tick();
    chk("brlu_state_run", 32'(state), 32'd0);
    chk("brlu_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("brlu_flush_cnt", 32'(flush_cnt), 32'd4);

    // Freeze inside a flush.
    br_TAKEN = 1'b1;
    tick();
    br_TAKEN = 1'b0;
    mem_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_ctl", 32'(ctl()), 32'h00);
      chk("frz_state", 32'(state), 32'd1);
      tick();
    end
    mem_BUSY = 1'b0;
    #1;
    chk("frz_wait_cnt", 32'(wait_cnt), 32'd3);
    chk("frz_rel_state", 32'(state), 32'd1);
    chk("frz_rel_ctl", 32'(ctl()), 32'h1F);
    tick();
    chk("frz_done_state", 32'(state), 32'd0);
    chk("frz_flush_cnt", 32'(flush_cnt), 32'd6);

    // 15-cycle busy run: no timeout.
    mem_BUSY = 1'b1;
    repeat (15) tick();
    mem_BUSY = 1'b0;
    #1;
    chk("to15_err", 32'(err_TIMEOUT), 32'd0);
    chk("to15_wait_cnt", 32'(wait_cnt), 32'd18);
    tick();

    // 16-cycle busy run: timeout on the 16th edge, sticky afterwards.
    mem_BUSY = 1'b1;
    repeat (15) tick();
    chk("to16_pre_err", 32'(err_TIMEOUT), 32'd0);
    tick();
    chk("to16_err", 32'(err_TIMEOUT), 32'd1);
    mem_BUSY = 1'b0;
    tick();
    tick();
    chk("to16_sticky", 32'(err_TIMEOUT), 32'd1);
    chk("to16_wait_cnt", 32'(wait_cnt), 32'd34);

    // Reset in the middle of a flush abandons it and clears everything.
    br_TAKEN = 1'b1;
    tick();
    br_TAKEN = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_err", 32'(err_TIMEOUT), 32'd0);
    chk("mid_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("mid_rst_ctl", 32'(ctl()), 32'h1A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control end of the IF/ID→EX/MEM pipeline register.
- Drives the register's ENABLE, plus PC and fetch enables.
- Requests NOP bubbles into the register on load-use hazards and taken branches.
- Freezes the whole front-end while data memory is busy.
- Keeps saturating performance counters and a sticky memory-timeout flag for debug.

Parameters:
LOAD_SEL, 2'b01, S_MXRB encoding meaning "writeback from data memory" (a load)
FLUSH_CYCLES, 2, bubble cycles per taken branch; legal range 1..7
MEM_TIMEOUT, 16, consecutive busy cycles that set err_TIMEOUT; legal range 1..65535

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
id_RA  in  4  source register A of the instruction in IF/ID
id_RB  in  4  source register B of the instruction in IF/ID
id_USE_A  in  1  instruction reads RA
id_USE_B  in  1  instruction reads RB
ex_WC  in  4  destination register held in the EX/MEM register (its out_WC)
ex_W_RB  in  1  EX/MEM instruction writes the register bank (its out_W_RB)
ex_S_MXRB  in  2  EX/MEM writeback source select (its out_S_MXRB)
br_TAKEN  in  1  branch resolved taken in EX this cycle
mem_BUSY  in  1  data memory not ready; pipeline must hold
EN_PC  out  1  PC register enable
EN_IF  out  1  fetch/instruction register enable
FLUSH_IF  out  1  clear fetched instruction (wrong path)
EN_IFID_EXMEM  out  1  ENABLE of the IF/ID→EX/MEM register
BUBBLE  out  1  force that register to load NOP fields: S_MXSE=1, OP_ALU=5'b10011 (passb), W_DM=0, W_RB=0, W_RF=0, WC=0
state  out  1  0=RUN, 1=FLUSH
stall_cnt  out  16  load-use stall cycles, saturating
flush_cnt  out  16  cycles with FLUSH_IF=1, saturating
wait_cnt  out  16  freeze cycles, saturating
err_TIMEOUT  out  1  sticky: a busy period reached MEM_TIMEOUT cycles

Behaviour:
- Control outputs are combinational from registered state plus inputs. Counters, state, flush counter (3b), busy run counter (16b) and err_TIMEOUT are registered.
- RESET=1 overrides all control outputs: EN_PC=0, EN_IF=0, FLUSH_IF=0, EN_IFID_EXMEM=1, BUBBLE=1, so a NOP is clocked into the pipeline register.
- On a clock edge with RESET=1:
  - state←RUN, flush counter←0, busy run←0.
  - all counters←0, err_TIMEOUT←0.
  - RESET mid-flush or mid-freeze abandons that operation.
- Load-use hazard (LU) = ex_W_RB & (ex_S_MXRB==LOAD_SEL) & ((id_USE_A & id_RA==ex_WC) | (id_USE_B & id_RB==ex_WC)). R0 is not special.
- Priority when RESET=0: mem_BUSY > (state==FLUSH) > br_TAKEN > LU > normal.
- Freeze (mem_BUSY=1, any state):
  - Outputs: all enables 0, BUBBLE=0, FLUSH_IF=0.
  - state and flush counter hold.
  - wait_cnt+1; busy run+1. When busy run reaches MEM_TIMEOUT, err_TIMEOUT←1 and stays set until RESET.
  - First cycle with mem_BUSY=0 resets busy run to 0 and is evaluated normally, with no extra latency.
- FLUSH state, not frozen:
  - Outputs: EN_PC=1, EN_IF=1, FLUSH_IF=1, EN_IFID_EXMEM=1, BUBBLE=1; flush_cnt+1.
  - br_TAKEN and LU are ignored (the EX stage holds a bubble).
  - Flush counter decrements. When it was 1, next state is RUN.
- RUN with br_TAKEN:
  - Outputs: same as FLUSH state; flush_cnt+1.
  - If FLUSH_CYCLES>1: state←FLUSH, flush counter←FLUSH_CYCLES-1. Otherwise stay RUN.
- RUN with LU (no branch):
  - Outputs: EN_PC=0, EN_IF=0, FLUSH_IF=0, EN_IFID_EXMEM=1, BUBBLE=1; stall_cnt+1.
  - Exactly one bubble per load. The next cycle sees the bubble in EX/MEM, so LU clears.
- RUN normal: EN_PC=EN_IF=EN_IFID_EXMEM=1, BUBBLE=0, FLUSH_IF=0.
- All counters saturate at 16'hFFFF and never wrap.

Test Plan:
- Reset: hold RESET 2 cycles with mem_BUSY=1, br_TAKEN=1 → EN_IFID_EXMEM=1, BUBBLE=1, EN_PC=0; after release: all counters 0, state=0, err_TIMEOUT=0.
- Load-use: ex_W_RB=1, ex_S_MXRB=2'b01, ex_WC=4'd5, id_RB=5, id_USE_B=1 → one cycle EN_PC=0, BUBBLE=1, stall_cnt=1. Same with ex_S_MXRB=2'b00 or id_USE_B=0 → no stall.
- Branch: br_TAKEN=1 for one cycle in RUN → FLUSH_IF=1, BUBBLE=1 for 2 cycles, state=1 in the second, then RUN; flush_cnt=2. br_TAKEN re-asserted during FLUSH is ignored.
- Branch+LU same cycle → branch response only; stall_cnt unchanged.
- Freeze inside flush: br_TAKEN, then mem_BUSY=1 for 3 cycles → all enables 0 for 3 cycles, wait_cnt=3, state stays 1; remaining flush cycle completes after release; flush_cnt=2.
- Timeout: mem_BUSY=1 for 16 cycles → err_TIMEOUT=1 after the 16th edge and stays 1 after mem_BUSY drops; 15-cycle busy run → stays 0.
